// File: rtl/display_timing_gen.sv
// Parametrised raster timing generator: counters, active-area coordinates, sync and strobes.
// Define DISPLAY_TIMING_REG_OUT_EN to register every output one cycle behind the counters.
module display_timing_gen #(
    parameter int CORDW    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             pix_clk,
    input  logic             rst_pix,
    input  logic             en,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic [CORDW-1:0] ax,
    output logic [CORDW-1:0] ay,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line,
    output logic             frame
);

    localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC;
    localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_AS   = CORDW'(H_BP);
    localparam logic [CORDW-1:0] H_AE   = CORDW'(H_BP + H_ACTIVE);
    localparam logic [CORDW-1:0] H_SS   = CORDW'(H_TOTAL - H_SYNC);
    localparam logic [CORDW-1:0] V_AS   = CORDW'(V_BP);
    localparam logic [CORDW-1:0] V_AE   = CORDW'(V_BP + V_ACTIVE);
    localparam logic [CORDW-1:0] V_SS   = CORDW'(V_TOTAL - V_SYNC);

    if (H_SYNC < 1 || V_SYNC < 1) begin : g_sync_chk
        $error("display_timing_gen: H_SYNC and V_SYNC must be at least 1");
    end
    if ((2 ** CORDW) < H_TOTAL || (2 ** CORDW) < V_TOTAL) begin : g_cordw_chk
        $error("display_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CORDW-1:0] sx_c, sy_c, ax_c, ay_c;
    logic             h_act, v_act, de_c, hsync_c, vsync_c, line_c, frame_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pix_clk or negedge rst_pix) begin
        if (!rst_pix) begin
            sx_c <= '0;
            sy_c <= '0;
        end else if (en) begin
            if (sx_c == H_LAST) begin
                sx_c <= '0;
                sy_c <= (sy_c == V_LAST) ? '0 : sy_c + 1'b1;
            end else begin
                sx_c <= sx_c + 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default first so no path through the block
    // leaves one unassigned and infers a latch.
    always_comb begin
        h_act   = 1'b0;
        v_act   = 1'b0;
        de_c    = 1'b0;
        ax_c    = '0;
        ay_c    = '0;
        hsync_c = !H_POL;
        vsync_c = !V_POL;
        line_c  = 1'b0;
        frame_c = 1'b0;

        h_act = (sx_c >= H_AS) && (sx_c < H_AE);
        v_act = (sy_c >= V_AS) && (sy_c < V_AE);
        de_c  = h_act && v_act;
        if (de_c) begin
            ax_c = sx_c - H_AS;
            ay_c = sy_c - V_AS;
        end
        // Sync is the last region, so the counter wrap bounds it from above.
        if (sx_c >= H_SS) hsync_c = H_POL;
        if (sy_c >= V_SS) vsync_c = V_POL;
        line_c  = en && rst_pix && (sx_c == '0);
        frame_c = line_c && (sy_c == '0);
    end

`ifdef DISPLAY_TIMING_REG_OUT_EN
    // Loads every cycle, independent of en, so outputs trail the counters by one clock.
    always_ff @(posedge pix_clk or negedge rst_pix) begin
        if (!rst_pix) begin
            sx    <= '0;
            sy    <= '0;
            ax    <= '0;
            ay    <= '0;
            de    <= 1'b0;
            hsync <= !H_POL;
            vsync <= !V_POL;
            line  <= 1'b0;
            frame <= 1'b0;
        end else begin
            sx    <= sx_c;
            sy    <= sy_c;
            ax    <= ax_c;
            ay    <= ay_c;
            de    <= de_c;
            hsync <= hsync_c;
            vsync <= vsync_c;
            line  <= line_c;
            frame <= frame_c;
        end
    end
`else
    assign sx    = sx_c;
    assign sy    = sy_c;
    assign ax    = ax_c;
    assign ay    = ay_c;
    assign de    = de_c;
    assign hsync = hsync_c;
    assign vsync = vsync_c;
    assign line  = line_c;
    assign frame = frame_c;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: default 640x480 raster scan plus a table-driven tiny raster.
`timescale 1ns/1ps
module tb_display_timing_gen;

`ifdef DISPLAY_TIMING_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    // default-parameter instance
    logic       rst_pix, en;
    logic [9:0] sx, sy, ax, ay;
    logic       de, hsync, vsync, line, frame;

    display_timing_gen dut (
        .pix_clk(pix_clk), .rst_pix(rst_pix), .en(en),
        .sx(sx), .sy(sy), .ax(ax), .ay(ay),
        .de(de), .hsync(hsync), .vsync(vsync), .line(line), .frame(frame)
    );

    // tiny raster: H total 8, V total 4, hsync active-high
    logic       s_rst, s_en;
    logic [3:0] s_sx, s_sy, s_ax, s_ay;
    logic       s_de, s_hsync, s_vsync, s_line, s_frame;

    display_timing_gen #(
        .CORDW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0)
    ) dut_s (
        .pix_clk(pix_clk), .rst_pix(s_rst), .en(s_en),
        .sx(s_sx), .sy(s_sy), .ax(s_ax), .ay(s_ay),
        .de(s_de), .hsync(s_hsync), .vsync(s_vsync), .line(s_line), .frame(s_frame)
    );

    typedef struct packed {
        logic [3:0] sx, sy, ax, ay;
        logic       de, hs, vs, ln, fr;
    } obs_t;

    typedef struct {
        logic en;
        obs_t exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input int x, input int y, input logic d,
                       input int a_x, input int a_y, input logic h, input logic v,
                       input logic l, input logic f);
        vec_t t;
        t.en     = e;
        t.exp.sx = 4'(x);
        t.exp.sy = 4'(y);
        t.exp.ax = 4'(a_x);
        t.exp.ay = 4'(a_y);
        t.exp.de = d;
        t.exp.hs = h;
        t.exp.vs = v;
        t.exp.ln = l;
        t.exp.fr = f;
        vecs.push_back(t);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c, x, y, px, py, last_line, nlines, found;
        int   bad_line, bad_frame, bad_period, bad_hs, bad_vs, bad_de, bad_cnt;
        int   hs_low0, de_cnt33, last_x, last_ax;
        int   first_x, first_y, first_ax, first_ay;
        bit   seen_de, exp_hs, exp_de;
        obs_t got, want, rst_obs;

        rst_pix = 1'b0; en = 1'b1;
        s_rst   = 1'b0; s_en = 1'b1;
        repeat (3) @(negedge pix_clk);
        #1;
        check("reset_state", {sx, sy, ax, ay, de, hsync, vsync, line, frame},
              {10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        rst_obs = '{sx: 4'd0, sy: 4'd0, ax: 4'd0, ay: 4'd0, de: 1'b0,
                    hs: 1'b0, vs: 1'b1, ln: 1'b0, fr: 1'b0};
        check("small_reset_state",
              {s_sx, s_sy, s_ax, s_ay, s_de, s_hsync, s_vsync, s_line, s_frame}, rst_obs);

        // ---- default raster: scan 34 lines plus a little ----
        @(negedge pix_clk);
        rst_pix = 1'b1;
        last_line = -1; nlines = 0; seen_de = 1'b0;
        bad_line = 0; bad_frame = 0; bad_period = 0; bad_hs = 0; bad_vs = 0;
        bad_de = 0; bad_cnt = 0; hs_low0 = 0; de_cnt33 = 0; last_x = -1; last_ax = -1;
        first_x = -1; first_y = -1; first_ax = -1; first_ay = -1; px = 0; py = 0;
        for (c = 0; c < 34 * 800 + 20; c++) begin
            #1;
            x = int'(sx);
            y = int'(sy);
            if (c == LAT) check("first_line_frame", {line, frame}, 2'b11);
            if (c >= LAT) begin
                if (line !== (x == 0)) bad_line++;
                if (frame !== (x == 0 && y == 0)) bad_frame++;
                if (line) begin
                    if (last_line >= 0 && c - last_line != 800) bad_period++;
                    last_line = c;
                    nlines++;
                end
            end
            if (c > LAT) begin
                if (x != ((px == 799) ? 0 : px + 1)) bad_cnt++;
                if (y != ((px == 799) ? py + 1 : py)) bad_cnt++;
            end
            exp_hs = !(x >= 704 && x <= 799);
            if (hsync !== exp_hs) bad_hs++;
            if (y == 0 && hsync == 1'b0) hs_low0++;
            if (vsync !== 1'b1) bad_vs++;
            exp_de = (x >= 48 && x < 688 && y >= 33 && y < 513);
            if (de !== exp_de) bad_de++;
            if (int'(ax) != (exp_de ? x - 48 : 0)) bad_de++;
            if (int'(ay) != (exp_de ? y - 33 : 0)) bad_de++;
            if (de && !seen_de) begin
                seen_de = 1'b1;
                first_x = x; first_y = y; first_ax = int'(ax); first_ay = int'(ay);
            end
            if (de && y == 33) begin
                de_cnt33++;
                last_x = x;
                last_ax = int'(ax);
            end
            px = x;
            py = y;
            @(negedge pix_clk);
        end
        check("line_vs_sx0", bad_line, 0);
        check("frame_vs_origin", bad_frame, 0);
        check("line_period_800", bad_period, 0);
        check("line_count", nlines, 35);
        check("counter_sequence", bad_cnt, 0);
        check("hsync_region", bad_hs, 0);
        check("hsync_low_cycles", hs_low0, 96);
        check("vsync_idle", bad_vs, 0);
        check("de_ax_ay_decode", bad_de, 0);
        check("first_de_pos", {first_x[15:0], first_y[15:0], first_ax[15:0], first_ay[15:0]},
              {16'd48, 16'd33, 16'd0, 16'd0});
        check("de_count_line33", de_cnt33, 640);
        check("last_de_line33", {last_x[15:0], last_ax[15:0]}, {16'd687, 16'd639});

        // ---- asynchronous reset mid-line ----
        found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            #1;
            if (sx == 10'd300) found = 1;
            else @(negedge pix_clk);
        end
        check("found_sx300", found, 1);
        #2;
        rst_pix = 1'b0;
        #1;
        check("async_reset", {sx, sy, ax, ay, de, hsync, vsync, line, frame},
              {10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        repeat (2) @(negedge pix_clk);
        #1;
        check("reset_held", {sx, sy, line}, {10'd0, 10'd0, 1'b0});
        @(negedge pix_clk);
        rst_pix = 1'b1;
        for (c = 0; c <= LAT + 800; c++) begin
            #1;
            if (c == LAT)
                check("restart_first", {sx, sy, line, frame}, {10'd0, 10'd0, 1'b1, 1'b1});
            if (c == LAT + 800)
                check("restart_next_line", {sx, sy, line, frame}, {10'd0, 10'd1, 1'b1, 1'b0});
            @(negedge pix_clk);
        end

        // ---- tiny raster, table driven ----
        add(1,0,0, 0,0,0, 0,1, 1,1);
        add(1,1,0, 0,0,0, 0,1, 0,0);
        add(0,2,0, 0,0,0, 0,1, 0,0);
        add(1,2,0, 0,0,0, 0,1, 0,0);
        add(1,3,0, 0,0,0, 0,1, 0,0);
        add(1,4,0, 0,0,0, 0,1, 0,0);
        add(1,5,0, 0,0,0, 0,1, 0,0);
        add(1,6,0, 0,0,0, 1,1, 0,0);
        add(1,7,0, 0,0,0, 1,1, 0,0);
        add(0,0,1, 0,0,0, 0,1, 0,0);
        add(1,0,1, 0,0,0, 0,1, 1,0);
        add(1,1,1, 1,0,0, 0,1, 0,0);
        add(1,2,1, 1,1,0, 0,1, 0,0);
        add(1,3,1, 1,2,0, 0,1, 0,0);
        add(1,4,1, 1,3,0, 0,1, 0,0);
        add(1,5,1, 0,0,0, 0,1, 0,0);
        add(1,6,1, 0,0,0, 1,1, 0,0);
        add(1,7,1, 0,0,0, 1,1, 0,0);
        add(1,0,2, 0,0,0, 0,1, 1,0);
        add(1,1,2, 1,0,1, 0,1, 0,0);
        add(1,2,2, 1,1,1, 0,1, 0,0);
        add(1,3,2, 1,2,1, 0,1, 0,0);
        add(1,4,2, 1,3,1, 0,1, 0,0);
        add(1,5,2, 0,0,0, 0,1, 0,0);
        add(1,6,2, 0,0,0, 1,1, 0,0);
        add(1,7,2, 0,0,0, 1,1, 0,0);
        add(1,0,3, 0,0,0, 0,0, 1,0);
        add(1,1,3, 0,0,0, 0,0, 0,0);
        add(1,2,3, 0,0,0, 0,0, 0,0);
        add(1,3,3, 0,0,0, 0,0, 0,0);
        add(1,4,3, 0,0,0, 0,0, 0,0);
        add(1,5,3, 0,0,0, 0,0, 0,0);
        add(1,6,3, 0,0,0, 1,0, 0,0);
        add(0,7,3, 0,0,0, 1,0, 0,0);
        add(0,7,3, 0,0,0, 1,0, 0,0);
        add(1,7,3, 0,0,0, 1,0, 0,0);
        add(1,0,0, 0,0,0, 0,1, 1,1);
        add(1,1,0, 0,0,0, 0,1, 0,0);

        s_en = vecs[0].en;
        @(negedge pix_clk);
        s_rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            s_en = vecs[i].en;
            #1;
            got  = {s_sx, s_sy, s_ax, s_ay, s_de, s_hsync, s_vsync, s_line, s_frame};
            want = (LAT == 0) ? vecs[i].exp : ((i == 0) ? rst_obs : vecs[i-1].exp);
            check($sformatf("small_step_%0d", i), got, want);
            @(negedge pix_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
